// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store bus master with alignment, lane steering and stall request.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        pipe_stall_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        sign_q, sign_d, err_q, err_d, req_q, req_d, we_q, we_d;
  logic        misalign, in_idle, start, tmo;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  assign misalign = (size_i == 2'b11) | (size_i == 2'b01 & addr_i[0]) | (size_i == 2'b10 & |addr_i[1:0]);
  assign in_idle  = state_q == IDLE;
  assign start    = in_idle & req_i & !misalign & !flush;
  assign tmo      = cnt_q == 8'(TIMEOUT - 1);
  assign lane_b   = bus_rdata_i[8*off_q +: 8];
  assign lane_h   = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  assign load_val = size_q == 2'b00 ? {{24{sign_q & lane_b[7]}}, lane_b} :
                    size_q == 2'b01 ? {{16{sign_q & lane_h[15]}}, lane_h} : bus_rdata_i;
  assign adel_o      = in_idle & req_i & misalign & !we_i;
  assign ades_o      = in_idle & req_i & misalign & we_i;
  assign done_o      = state_q == DONE;
  assign stallreq_o  = in_idle ? req_i & !misalign : state_q == WAIT ? 1'b1 : state_q == DRAIN ? req_i : 1'b0;
  assign rdata_o     = rdata_q;
  assign bus_err_o   = err_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = WAIT;
        cnt_d   = 8'd0;
        req_d   = 1'b1;
        we_d    = we_i;
        addr_d  = {addr_i[31:2], 2'b00};
        be_d    = !we_i ? 4'hF : size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
                  size_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'hF;
        wdata_d = size_i == 2'b00 ? {4{wdata_i[7:0]}} : size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        size_d  = size_i;
        off_d   = addr_i[1:0];
        sign_d  = sign_i;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          // an ack coincident with flush completes the bus cycle, so nothing is left to drain
          state_d = bus_ack_i ? IDLE : DRAIN;
          req_d   = !bus_ack_i;
          cnt_d   = 8'd0;
        end else if (bus_ack_i) begin
          state_d = DONE;
          rdata_d = load_val;
          err_d   = 1'b0;
          req_d   = 1'b0;
        end else if (tmo) begin
          state_d = DONE;
          rdata_d = 32'd0;
          err_d   = 1'b1;
          req_d   = 1'b0;
        end
      end
      DONE: state_d = (pipe_stall_i & !flush) ? DONE : IDLE;
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack_i | tmo) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sign_q  <= sign_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vector table plus hand sequences for drain, timeout, hold and reset.
module tb_mem_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, pipe_stall = 1'b0, req = 1'b0, we = 1'b0, sign = 1'b0, ack = 1'b0;
  logic [1:0]  size = 2'b0;
  logic [31:0] addr = '0, wdata = '0, brdata = '0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic done, stallreq, adel, ades, bus_err, bus_req, bus_we;
  int total = 0, bad = 0;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pipe_stall_i(pipe_stall), .req_i(req), .we_i(we),
    .size_i(size), .sign_i(sign), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done),
    .stallreq_o(stallreq), .adel_o(adel), .ades_o(ades), .bus_err_o(bus_err), .bus_req_o(bus_req),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_ack_i(ack), .bus_rdata_i(brdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [1:0] s, input logic sg, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; sign = sg; addr = a; wdata = d;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr, wdata, brd, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    logic        mis;
  } vec_t;
  vec_t v[13];

  initial begin
    int n;
    v[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h8899AABB, 32'h100, 4'hF,    32'h0,        32'h8899AABB, 1'b0};
    v[1]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80123456, 32'h100, 4'hF,    32'h0,        32'hFFFFFF80, 1'b0};
    v[2]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80123456, 32'h100, 4'hF,    32'h0,        32'h00000080, 1'b0};
    v[3]  = '{1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'hBEEF0000, 32'h100, 4'hF,    32'h0,        32'h0000BEEF, 1'b0};
    v[4]  = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'hBEEF0000, 32'h100, 4'hF,    32'h0,        32'hFFFFBEEF, 1'b0};
    v[5]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h00007F00, 32'h100, 4'hF,    32'h0,        32'h0000007F, 1'b0};
    v[6]  = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h5A,       32'h0,        32'h200, 4'b0010, 32'h5A5A5A5A, 32'h0,        1'b0};
    v[7]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF1234, 32'h0,        32'h200, 4'b1100, 32'h12341234, 32'h0,        1'b0};
    v[8]  = '{1'b1, 2'b10, 1'b0, 32'h030, 32'hDEADBEEF, 32'h0,        32'h030, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0};
    v[9]  = '{1'b1, 2'b01, 1'b0, 32'h203, 32'h0,        32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1};
    v[10] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1};
    v[11] = '{1'b0, 2'b11, 1'b0, 32'h000, 32'h0,        32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1};
    v[12] = '{1'b0, 2'b01, 1'b0, 32'h001, 32'h0,        32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1};

    tick(); tick();
    chk("rst_rdata", rdata, 0); chk("rst_err", bus_err, 0); chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0); chk("rst_addr", bus_addr, 0); chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0); chk("rst_done", done, 0); chk("rst_stall", stallreq, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      set_req(v[i].we, v[i].size, v[i].sign, v[i].addr, v[i].wdata);
      #1;
      chk($sformatf("v%0d_stall", i), stallreq, !v[i].mis);
      chk($sformatf("v%0d_adel", i), adel, v[i].mis & !v[i].we);
      chk($sformatf("v%0d_ades", i), ades, v[i].mis & v[i].we);
      tick();
      if (v[i].mis) begin
        chk($sformatf("v%0d_noreq", i), bus_req, 0);
        req = 1'b0;
      end else begin
        chk($sformatf("v%0d_req", i), bus_req, 1);
        chk($sformatf("v%0d_we", i), bus_we, v[i].we);
        chk($sformatf("v%0d_addr", i), bus_addr, v[i].e_addr);
        chk($sformatf("v%0d_be", i), bus_be, v[i].e_be);
        if (v[i].we) chk($sformatf("v%0d_wdata", i), bus_wdata, v[i].e_wd);
        ack = 1'b1; brdata = v[i].brd;
        tick();
        ack = 1'b0; req = 1'b0;
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_stall_done", i), stallreq, 0);
        chk($sformatf("v%0d_err", i), bus_err, 0);
        if (!v[i].we) chk($sformatf("v%0d_rdata", i), rdata, v[i].e_rd);
        tick();
        chk($sformatf("v%0d_idle", i), done, 0);
      end
    end

    // load word, ack after two wait cycles
    n = 0;
    set_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #1; n += int'(stallreq);
    tick(); n += int'(stallreq);
    chk("lw2_addr", bus_addr, 32'h100); chk("lw2_be", bus_be, 4'hF);
    tick(); n += int'(stallreq);
    ack = 1'b1; brdata = 32'h8899AABB;
    tick(); n += int'(stallreq);
    ack = 1'b0; req = 1'b0;
    chk("lw2_done", done, 1); chk("lw2_rdata", rdata, 32'h8899AABB); chk("lw2_stallcycles", n, 3);
    tick();

    // flush in second wait cycle, then drain while a new request waits
    set_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("dr_req1", bus_req, 1); chk("dr_done1", done, 0);
    set_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    #1; chk("dr_stall", stallreq, 1);
    tick();
    chk("dr_req2", bus_req, 1); chk("dr_done2", done, 0);
    ack = 1'b1; brdata = 32'hDEAD0000;
    tick();
    ack = 1'b0;
    chk("dr_reqdrop", bus_req, 0); chk("dr_nodone", done, 0); chk("dr_stall_idle", stallreq, 1);
    tick();
    chk("dr_new_req", bus_req, 1); chk("dr_new_addr", bus_addr, 32'h80);
    ack = 1'b1; brdata = 32'h11223344;
    tick();
    ack = 1'b0; req = 1'b0;
    chk("dr_new_done", done, 1); chk("dr_new_rdata", rdata, 32'h11223344);
    tick();

    // timeout without ack
    n = 0;
    set_req(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
    tick();
    for (int k = 0; k < 10 && !done; k++) begin
      n += int'(bus_req);
      tick();
    end
    req = 1'b0;
    chk("to_done", done, 1); chk("to_reqcycles", n, 4);
    chk("to_err", bus_err, 1); chk("to_rdata", rdata, 0);
    tick();

    // pipe_stall holds DONE without reissuing
    n = 0;
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    n += int'(bus_req);
    ack = 1'b1; brdata = 32'hCAFEF00D; pipe_stall = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ps_done%0d", k), done, 1);
      chk($sformatf("ps_rdata%0d", k), rdata, 32'hCAFEF00D);
      n += int'(bus_req);
      tick();
    end
    pipe_stall = 1'b0;
    chk("ps_done3", done, 1); chk("ps_err", bus_err, 0);
    req = 1'b0;
    tick();
    n += int'(bus_req);
    chk("ps_released", done, 0); chk("ps_reqcycles", n, 1);

    // reset in the middle of a store
    set_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    tick();
    chk("rw_req", bus_req, 1);
    rst = 1'b1; req = 1'b0;
    tick();
    chk("rw_req0", bus_req, 0); chk("rw_we0", bus_we, 0); chk("rw_addr0", bus_addr, 0);
    chk("rw_be0", bus_be, 0); chk("rw_wdata0", bus_wdata, 0); chk("rw_rdata0", rdata, 0);
    chk("rw_done0", done, 0); chk("rw_stall0", stallreq, 0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
